// File: rtl/i_cache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
package i_cache_pkg;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  localparam int BLOCK_W    = 128;
  localparam int WORD_W     = 32;
  localparam int BLK_ADDR_W = 28;

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets);
    return BLK_ADDR_W - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/i_cache_fsm.sv
// Miss-handling controller: owns the memory-side handshake, the latched
// block address and the single-cycle line write strobe.
module i_cache_fsm
  import i_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  pc_valid,
  input  logic                  hit,
  input  logic [BLK_ADDR_W-1:0] pc_blk,
  input  logic                  mem_busywait,
  output logic                  mem_read_en,
  output logic [BLK_ADDR_W-1:0] blk_addr,
  output logic                  upd_we,
  output logic                  miss_start,
  output logic                  fsm_busy,
  output logic                  idle
);

  state_t state_q, state_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Block address is captured once per miss and held for the whole fill.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          blk_addr <= '0;
    else if (miss_start) blk_addr <= pc_blk;
  end

  always_comb begin
    state_d     = state_q;
    mem_read_en = 1'b0;
    upd_we      = 1'b0;
    miss_start  = 1'b0;
    fsm_busy    = 1'b0;
    idle        = 1'b0;
    case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (pc_valid && !hit) begin
          miss_start = 1'b1;
          fsm_busy   = 1'b1;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read_en = 1'b1;
        fsm_busy    = 1'b1;
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        // Memory finished on the previous edge; data is stable only now.
        upd_we   = 1'b1;
        fsm_busy = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped instruction cache, zero-wait hits, 128-bit block refill.
// Optional ICACHE_STATS_EN adds HIT_COUNT / MISS_COUNT outputs.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PC_VALID,
  input  logic [31:0]           PC,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  CPU_BUSYWAIT,
  output logic                  MEM_READ_EN,
  output logic [BLK_ADDR_W-1:0] MEM_READ_ADDR,
  input  logic [BLOCK_W-1:0]    MEM_READ_DATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
`endif
);

  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(NUM_SETS);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_arr [NUM_SETS];

  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [1:0]            pc_word;
  logic [BLOCK_W-1:0]    line;
  logic                  hit;
  logic [BLK_ADDR_W-1:0] blk_addr;
  logic                  upd_we, miss_start, fsm_busy, idle;
  logic [IDX_W-1:0]      upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = ^PC[1:0];
  assign pc_word = PC[3:2];
  assign pc_idx  = PC[4 +: IDX_W];
  assign pc_tag  = PC[4+IDX_W +: TAG_W];

  assign line        = data_arr[pc_idx];
  assign hit         = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign INSTRUCTION = hit ? line[{pc_word, 5'b0} +: WORD_W] : '0;

  assign CPU_BUSYWAIT  = !RESET || fsm_busy;
  assign MEM_READ_ADDR = blk_addr;
  assign upd_idx       = blk_addr[IDX_W-1:0];
  assign upd_tag       = blk_addr[BLK_ADDR_W-1:IDX_W];

  i_cache_fsm u_fsm (
    .CLK          (CLK),
    .RESET        (RESET),
    .pc_valid     (PC_VALID),
    .hit          (hit),
    .pc_blk       (PC[31:4]),
    .mem_busywait (MEM_BUSYWAIT),
    .mem_read_en  (MEM_READ_EN),
    .blk_addr     (blk_addr),
    .upd_we       (upd_we),
    .miss_start   (miss_start),
    .fsm_busy     (fsm_busy),
    .idle         (idle)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      valid_q          <= '0;
    else if (upd_we) valid_q[upd_idx] <= 1'b1;
  end

  // Tag and data storage carry no reset; valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (upd_we) begin
      tag_arr[upd_idx]  <= upd_tag;
      data_arr[upd_idx] <= MEM_READ_DATA;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (idle && PC_VALID && hit) HIT_COUNT  <= HIT_COUNT + 32'd1;
      if (miss_start)              MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule
